// File: rtl/dcol_readout_arbiter_pkg.sv
// Shared definitions for the double-column readout arbiter.
//   - Slot phase encodings (2-bit phase count, one slot = ARB, LOAD, XFER, ADV).
//   - Default emulator sizing (NREQ/DW/IW).
//   - wrap_inc: round-robin pointer advance helper.
package dcol_readout_arbiter_pkg;

   localparam logic [1:0] ST_ARB  = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_XFER = 2'd2;
   localparam logic [1:0] ST_ADV  = 2'd3;

   localparam int unsigned NREQ_DEF = 8;
   localparam int unsigned DW_DEF   = 24;
   localparam int unsigned IW_DEF   = 3;

   // Next column after idx, wrapping to 0 after the last requester.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/dcol_readout_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req scanning ptr, ptr+1, ...
// wrapping modulo NREQ.
// Ports:
//   req  in  NREQ  request vector
//   ptr  in  IW    search start (always < NREQ)
//   any  out 1     some request is set
//   idx  out IW    index of the first set request from ptr (0 when any=0)
module dcol_readout_arbiter_rr_pick #(
   parameter int unsigned NREQ = 8,
   parameter int unsigned IW   = 3
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            any,
   output logic [IW-1:0]   idx
);

   always_comb begin
      int unsigned j;
      j   = 0;
      any = |req;
      idx = '0;
      // Scan from the farthest offset down so the nearest hit is written last and wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = 32'(ptr) + 32'(k);
         if (j >= NREQ) j = j - NREQ;
         if (req[j]) idx = IW'(j);
      end
   end

endmodule

// File: rtl/dcol_readout_arbiter.sv
// Round-robin arbiter sharing the emulator readout bus among NREQ double columns.
// Each grant runs a fixed 4-phase slot: ARB -> LOAD -> XFER (waits for out_ready) -> ADV.
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   enable               allows a new grant (sampled in ARB only)
//   req, data_in         per-column pending flag and flattened words (column i at [i*DW +: DW])
//   ack                  one-cycle one-hot pop pulse to the granted column
//   out_valid/out_ready  handshake to the serializer; out_data/out_col carry the word
//   slot_cnt             current phase, empty_phase toggles once per completed slot
//   idle                 in ARB and not taking a grant this cycle
module dcol_readout_arbiter
   import dcol_readout_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned IW   = IW_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] data_in,
   output logic [NREQ-1:0]    ack,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DW-1:0]      out_data,
   output logic [IW-1:0]      out_col,
   output logic [1:0]         slot_cnt,
   output logic               empty_phase,
   output logic               idle
);

   localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

   logic [IW-1:0] rr_ptr_q;
   logic [IW-1:0] winner_q;
   logic          pick_any;
   logic [IW-1:0] pick_idx;

   dcol_readout_arbiter_rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .req (req),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot_cnt    <= ST_ARB;
         ack         <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_col     <= '0;
         empty_phase <= 1'b0;
         rr_ptr_q    <= '0;
         winner_q    <= '0;
      end else begin
         ack <= '0;
         case (slot_cnt)
            ST_ARB: begin
               if (enable && pick_any) begin
                  winner_q <= pick_idx;
                  slot_cnt <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               // req is not re-checked: the word is taken even if req[winner] dropped.
               out_data  <= data_in[winner_q*DW +: DW];
               out_col   <= winner_q;
               out_valid <= 1'b1;
               ack       <= ONE_HOT0 << winner_q;
               slot_cnt  <= ST_XFER;
            end
            ST_XFER: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  slot_cnt  <= ST_ADV;
               end
            end
            ST_ADV: begin
               rr_ptr_q    <= IW'(wrap_inc(32'(winner_q), NREQ));
               empty_phase <= ~empty_phase;
               slot_cnt    <= ST_ARB;
            end
            default: slot_cnt <= ST_ARB;
         endcase
      end
   end

   // Reset counts as "no grant taken" so idle reads 1 while reset is held.
   assign idle = (slot_cnt == ST_ARB) && (reset || !(enable && pick_any));

endmodule

// File: tb/tb_dcol_readout_arbiter.sv
module tb_dcol_readout_arbiter;

   localparam int NREQ = 8;
   localparam int DW   = 24;
   localparam int IW   = 3;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               enable = 1'b1;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ*DW-1:0] data_in = '0;
   logic [NREQ-1:0]    ack;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [DW-1:0]      out_data;
   logic [IW-1:0]      out_col;
   logic [1:0]         slot_cnt;
   logic               empty_phase;
   logic               idle;

   int n_checks = 0;
   int n_fail   = 0;

   dcol_readout_arbiter #(
      .NREQ (NREQ),
      .DW   (DW),
      .IW   (IW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .req         (req),
      .data_in     (data_in),
      .ack         (ack),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_col     (out_col),
      .slot_cnt    (slot_cnt),
      .empty_phase (empty_phase),
      .idle        (idle)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      req = '0; enable = 1'b1; out_ready = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      int r = -1;
      int n = 0;
      for (int i = 0; i < NREQ; i++) if (v[i]) begin r = i; n++; end
      return (n == 1) ? r : -1;
   endfunction

   task automatic wait_ack(output logic [NREQ-1:0] a);
      a = '0;
      for (int i = 0; i < 20 && a == '0; i++) begin
         tick();
         a = ack;
      end
   endtask

   task automatic test_reset();
      do_reset();
      req = 8'h10;
      tick(); tick();
      req = '0;
      tick(); tick();                       // slot for column 4 done, pointer now 5
      req = 8'h41; out_ready = 1'b0;
      tick(); tick();                       // mid-slot on column 6
      reset = 1'b1;
      #1;
      n_checks++; if (ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %h want 00", ack); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_checks++; if (slot_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_slot: got %0d want 0", slot_cnt); end
      n_checks++; if (empty_phase !== 1'b0) begin n_fail++; $display("FAIL reset_ep: got %b want 0", empty_phase); end
      n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
      @(posedge clock); #1;
      reset = 1'b0; out_ready = 1'b1;
      tick(); tick();
      n_checks++; if (ack !== 8'h01) begin n_fail++; $display("FAIL reset_regrant_ack: got %h want 01", ack); end
      n_checks++; if (out_col !== 3'd0) begin n_fail++; $display("FAIL reset_regrant_col: got %0d want 0", out_col); end
      req = '0;
      tick(); tick();
   endtask

   task automatic test_single();
      do_reset();
      data_in[2*DW +: DW] = 24'hABCDEF;
      req = 8'h04;
      #1;
      n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", idle); end
      tick();
      n_checks++; if (ack !== '0) begin n_fail++; $display("FAIL single_ack_e1: got %h want 00", ack); end
      n_checks++; if (slot_cnt !== 2'd1) begin n_fail++; $display("FAIL single_slot_e1: got %0d want 1", slot_cnt); end
      tick();
      n_checks++; if (ack !== 8'h04) begin n_fail++; $display("FAIL single_ack_e2: got %h want 04", ack); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_e2: got %b want 1", out_valid); end
      n_checks++; if (out_data !== 24'hABCDEF) begin n_fail++; $display("FAIL single_data: got %h want abcdef", out_data); end
      n_checks++; if (out_col !== 3'd2) begin n_fail++; $display("FAIL single_col: got %0d want 2", out_col); end
      req = '0;
      tick();
      n_checks++; if (ack !== '0) begin n_fail++; $display("FAIL single_ack_e3: got %h want 00", ack); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_e3: got %b want 0", out_valid); end
      n_checks++; if (empty_phase !== 1'b0) begin n_fail++; $display("FAIL single_ep_e3: got %b want 0", empty_phase); end
      tick();
      n_checks++; if (empty_phase !== 1'b1) begin n_fail++; $display("FAIL single_ep_e4: got %b want 1", empty_phase); end
      n_checks++; if (slot_cnt !== 2'd0) begin n_fail++; $display("FAIL single_slot_e4: got %0d want 0", slot_cnt); end
      req = 8'h0D;                          // columns 0,2,3: search restarts at 3
      tick(); tick();
      n_checks++; if (ack !== 8'h08) begin n_fail++; $display("FAIL single_next_ptr: got %h want 08", ack); end
      req = '0;
      tick(); tick();
   endtask

   task automatic test_rotation();
      int grants[$];
      int toggles = 0;
      logic prev_ep;
      do_reset();
      req = 8'hFF;
      prev_ep = empty_phase;
      for (int c = 1; c <= 36; c++) begin
         tick();
         if (empty_phase !== prev_ep) toggles++;
         prev_ep = empty_phase;
         if (ack !== '0) begin
            grants.push_back(onehot_idx(ack));
            n_checks++;
            if ((c % 4) != 2) begin n_fail++; $display("FAIL rot_ack_cycle: got cycle %0d want 2 mod 4", c); end
         end
      end
      req = '0;
      n_checks++; if (grants.size() != 9) begin n_fail++; $display("FAIL rot_count: got %0d want 9", grants.size()); end
      for (int k = 0; k < grants.size() && k < 9; k++) begin
         n_checks++;
         if (grants[k] != (k % NREQ)) begin n_fail++; $display("FAIL rot_order[%0d]: got %0d want %0d", k, grants[k], k % NREQ); end
      end
      n_checks++; if (toggles != 9) begin n_fail++; $display("FAIL rot_toggles: got %0d want 9", toggles); end
   endtask

   task automatic test_stall();
      logic [DW-1:0] w;
      int nx = 0;
      do_reset();
      w = DW'($urandom);
      data_in[1*DW +: DW] = w;
      out_ready = 1'b0;
      req = 8'h02;
      tick(); tick();
      n_checks++; if (ack !== 8'h02) begin n_fail++; $display("FAIL stall_ack: got %h want 02", ack); end
      req = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (out_valid && out_ready) nx++;
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); end
         n_checks++; if (out_data !== w) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", i, out_data, w); end
         n_checks++; if (slot_cnt !== 2'd2) begin n_fail++; $display("FAIL stall_slot[%0d]: got %0d want 2", i, slot_cnt); end
         n_checks++; if (ack !== '0) begin n_fail++; $display("FAIL stall_ack[%0d]: got %h want 00", i, ack); end
      end
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) nx++;
      tick();
      if (out_valid && out_ready) nx++;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid: got %b want 0", out_valid); end
      n_checks++; if (slot_cnt !== 2'd3) begin n_fail++; $display("FAIL stall_release_slot: got %0d want 3", slot_cnt); end
      n_checks++; if (nx != 1) begin n_fail++; $display("FAIL stall_transfers: got %0d want 1", nx); end
      tick();
   endtask

   task automatic test_wrap();
      logic [NREQ-1:0] a;
      do_reset();
      req = 8'h40;
      wait_ack(a);
      n_checks++; if (a !== 8'h40) begin n_fail++; $display("FAIL wrap_first: got %h want 40", a); end
      req = 8'h81;
      wait_ack(a);
      n_checks++; if (a !== 8'h80) begin n_fail++; $display("FAIL wrap_ack7: got %h want 80", a); end
      n_checks++; if (out_col !== 3'd7) begin n_fail++; $display("FAIL wrap_col7: got %0d want 7", out_col); end
      req = 8'h01;
      wait_ack(a);
      n_checks++; if (a !== 8'h01) begin n_fail++; $display("FAIL wrap_ack0: got %h want 01", a); end
      n_checks++; if (out_col !== 3'd0) begin n_fail++; $display("FAIL wrap_col0: got %0d want 0", out_col); end
      req = '0;
      tick(); tick(); tick();
   endtask

   task automatic test_enable();
      do_reset();
      enable = 1'b0; out_ready = 1'b0;
      req = 8'h10;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++; if (ack !== '0) begin n_fail++; $display("FAIL en_ack[%0d]: got %h want 00", i, ack); end
         n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL en_idle[%0d]: got %b want 1", i, idle); end
         n_checks++; if (slot_cnt !== 2'd0) begin n_fail++; $display("FAIL en_slot[%0d]: got %0d want 0", i, slot_cnt); end
      end
      enable = 1'b1;
      tick();
      n_checks++; if (ack !== '0) begin n_fail++; $display("FAIL en_ack_e1: got %h want 00", ack); end
      tick();
      n_checks++; if (ack !== 8'h10) begin n_fail++; $display("FAIL en_ack_e2: got %h want 10", ack); end
      enable = 1'b0; req = '0;              // dropped while the slot waits in XFER
      tick(); tick();
      n_checks++; if (slot_cnt !== 2'd2) begin n_fail++; $display("FAIL en_xfer_hold: got %0d want 2", slot_cnt); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL en_xfer_valid: got %b want 1", out_valid); end
      out_ready = 1'b1;
      tick();
      n_checks++; if (slot_cnt !== 2'd3) begin n_fail++; $display("FAIL en_adv: got %0d want 3", slot_cnt); end
      tick();
      n_checks++; if (slot_cnt !== 2'd0) begin n_fail++; $display("FAIL en_done_slot: got %0d want 0", slot_cnt); end
      n_checks++; if (empty_phase !== 1'b1) begin n_fail++; $display("FAIL en_done_ep: got %b want 1", empty_phase); end
      enable = 1'b1;
   endtask

   // Static per-column backlogs: the order of grants is fixed by the round-robin rule
   // regardless of random enable/out_ready timing.
   logic [DW-1:0] words [NREQ][4];
   int            cnt   [NREQ];
   int            head  [NREQ];

   task automatic refresh_inputs();
      for (int c = 0; c < NREQ; c++) begin
         req[c] = (head[c] < cnt[c]);
         data_in[c*DW +: DW] = (head[c] < cnt[c]) ? words[c][head[c]] : '0;
      end
   endtask

   task automatic test_random();
      int            exp_col[$];
      logic [DW-1:0] exp_dat[$];
      int            th[NREQ];
      int            ptr = 0;
      int            left = 0;
      int            total, gi = 0, xi = 0, idx, c;
      bit            found;
      do_reset();
      for (int k = 0; k < NREQ; k++) begin
         cnt[k] = $urandom_range(0, 3);
         head[k] = 0;
         th[k] = 0;
         for (int m = 0; m < 4; m++) words[k][m] = DW'($urandom);
      end
      if (cnt[NREQ-1] == 0) cnt[NREQ-1] = 1;
      for (int k = 0; k < NREQ; k++) left += cnt[k];
      total = left;
      while (left > 0) begin
         found = 1'b0;
         for (int k = 0; k < NREQ && !found; k++) begin
            c = (ptr + k) % NREQ;
            if (th[c] < cnt[c]) begin
               exp_col.push_back(c);
               exp_dat.push_back(words[c][th[c]]);
               th[c]++;
               ptr = (c + 1) % NREQ;
               left--;
               found = 1'b1;
            end
         end
      end
      refresh_inputs();
      for (int cyc = 0; cyc < 3000 && xi < total; cyc++) begin
         tick();
         enable = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         if (ack !== '0) begin
            idx = onehot_idx(ack);
            n_checks++;
            if (gi >= total || idx != exp_col[gi]) begin
               n_fail++;
               $display("FAIL rand_grant[%0d]: got ack %h want column %0d", gi, ack,
                        (gi < total) ? exp_col[gi] : -1);
            end
            if (idx >= 0) head[idx]++;
            gi++;
            refresh_inputs();
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (xi >= total || out_col !== IW'(exp_col[xi]) || out_data !== exp_dat[xi]) begin
               n_fail++;
               $display("FAIL rand_xfer[%0d]: got col %0d data %h want col %0d data %h", xi,
                        out_col, out_data, (xi < total) ? exp_col[xi] : -1,
                        (xi < total) ? exp_dat[xi] : '0);
            end
            xi++;
         end
      end
      n_checks++; if (xi != total) begin n_fail++; $display("FAIL rand_xfer_count: got %0d want %0d", xi, total); end
      n_checks++; if (gi != total) begin n_fail++; $display("FAIL rand_ack_count: got %0d want %0d", gi, total); end
      enable = 1'b1; out_ready = 1'b1; req = '0;
      tick(); tick(); tick(); tick();
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      test_reset();
      test_single();
      test_rotation();
      test_stall();
      test_wrap();
      test_enable();
      for (int r = 0; r < 5; r++) test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dcol_readout_arbiter.md
Name: dcol_readout_arbiter

Overview:
- Round-robin arbiter that shares the single readout bus of the FE-I4 emulator among NREQ double-column requesters.
- Each grant is sequenced as a fixed 4-phase slot. The 2-bit phase count and the per-slot toggling empty-phase flag follow the same convention as the emulator's existing empty flag: toggle when the count is 3.
- Sits between the column hit buffers and the serializer/frame builder.

Parameters:
- NREQ, 8, number of requesting double columns (2..16).
- DW, 24, width of one readout word.
- IW, 3, width of the column index; must satisfy 2**IW >= NREQ.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  allows new grants; sampled only in phase ARB.
- req  in  NREQ  req[i]=1: column i has a word pending; held until ack[i].
- data_in  in  NREQ*DW  flattened words; column i occupies bits [i*DW +: DW].
- ack  out  NREQ  one-hot, one-cycle pulse; column i pops its word.
- out_valid  out  1  out_data/out_col valid.
- out_ready  in  1  downstream accepts the word when out_valid&&out_ready.
- out_data  out  DW  granted word.
- out_col  out  IW  index of the granted column.
- slot_cnt  out  2  current phase (0=ARB, 1=LOAD, 2=XFER, 3=ADV).
- empty_phase  out  1  toggles once per completed slot.
- idle  out  1  high when in ARB with no grant being taken.

Behaviour:
- Reset (async) values: slot_cnt=0 (ARB), ack=0, out_valid=0, out_data=0, out_col=0, empty_phase=0, rr_ptr=0, winner=0, idle=1. A word in flight at reset is dropped; its ack is never reissued.
- ARB (0):
  - If enable=1 and req!=0: winner <= first set req index scanning rr_ptr, rr_ptr+1, ... wrapping modulo NREQ; next state LOAD.
  - Otherwise stay in ARB; idle=1.
- LOAD (1):
  - out_data <= data_in[winner], out_col <= winner, out_valid <= 1, ack[winner] <= 1 for exactly one cycle; next state XFER.
  - req is not re-sampled. If req[winner] dropped after ARB, the captured word is still transferred.
- XFER (2):
  - On an edge with out_ready=1: out_valid <= 0; next state ADV.
  - Otherwise hold: out_valid, out_data and out_col stay stable; slot_cnt stays at 2.
- ADV (3): rr_ptr <= (winner==NREQ-1) ? 0 : winner+1; empty_phase <= ~empty_phase; next state ARB.
- Latency:
  - req present in an ARB cycle -> out_valid and ack high after the 2nd rising edge.
  - Minimum slot is 4 cycles, so peak throughput is 1 word per 4 clocks.
- enable:
  - Deassertion never aborts a slot in progress; it only blocks the next ARB.
  - enable=0 in ARB: no ack, slot_cnt=0, idle=1.
- Simultaneous events:
  - All requesters set -> strict rotation by rr_ptr.
  - A requester re-asserting req in the cycle after its ack is eligible at the next ARB but only wins if it is first from rr_ptr.
- Wrap: rr_ptr=NREQ-1 and req has bits NREQ-1 and 0 set -> grants NREQ-1, then 0.
- Indices >= NREQ never appear on out_col or ack.
- All outputs are registered except idle, which is decoded from state and enable/req.

Decomposition:
- Shared include/package holds:
  - phase encodings ST_ARB=2'd0, ST_LOAD=2'd1, ST_XFER=2'd2, ST_ADV=2'd3;
  - default NREQ/DW/IW constants for the emulator.
- Sub-module rr_pick: combinational first-set search from pointer.
  - Inputs: req[NREQ], ptr[IW].
  - Outputs: any, idx[IW].
  - Verified standalone.

Test Plan:
1. Assert reset mid-run -> immediately ack=0, out_valid=0, slot_cnt=0, empty_phase=0, idle=1; after release req=8'h01 grants column 0 (rr_ptr back to 0).
2. req=8'b0000_0100, data_in[2]=24'hABCDEF, out_ready=1, enable=1 -> ack=8'h04 for one cycle at edge 2; out_valid=1 for one cycle with out_data=24'hABCDEF, out_col=2; empty_phase 0->1 at edge 4; next grant starts search at column 3.
3. req=8'hFF held, out_ready=1 -> grant order 0,1,2,...,7,0; one ack every 4 cycles; empty_phase toggles 9 times over 36 cycles.
4. Single grant with out_ready=0 for 5 cycles -> out_valid held high with out_data stable, slot_cnt=2 throughout, no further ack; ready=1 completes the slot with exactly one transfer.
5. After a grant to column 6, req=8'b1000_0001 -> grants 7 then 0 (wrap), out_col 7 then 0.
6. enable=0 with req=8'h10 for 10 cycles -> no ack, idle=1, slot_cnt=0; enable=1 -> ack=8'h10 two edges later. Drop enable during XFER -> slot still completes.
